i2s_tx_dsp_sched: RTL and testbench

I2S_TX_DSP_SCHED -- requirements
Module: i2s_tx_dsp_sched

---
 rtl/i2s_tx_dsp_sched.sv | 155 +++++++++++++++
 tb/tb_i2s_tx_dsp_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_dsp_sched.sv
// rtl/i2s_tx_dsp_sched.sv - I2S TX scheduler: interleaves ch0/ch1 samples into a one-entry buffer feeding the TX DSP channel
module i2s_tx_dsp_sched (
    input  logic        sck_i,
    input  logic        rstn_i,
    input  logic        cfg_en_i,
    input  logic        cfg_2ch_i,
    input  logic [3:0]  cfg_num_word_i,
    input  logic [31:0] ch0_data_i,
    input  logic        ch0_valid_i,
    output logic        ch0_ready_o,
    input  logic [31:0] ch1_data_i,
    input  logic        ch1_valid_i,
    output logic        ch1_ready_o,
    output logic [31:0] fifo_data_o,
    output logic        fifo_data_valid_o,
    input  logic        fifo_data_ready_i,
    input  logic        master_ready_to_send_i,
    output logic        tx_en_o,
    output logic        frame_done_o,
    output logic        underrun_o,
    output logic [7:0]  underrun_cnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        tx_en_q, tx_en_d;
    logic [31:0] fifo_data_q, fifo_data_d;
    logic        fifo_valid_q, fifo_valid_d;
    logic        sel_q, sel_d;
    logic [4:0]  word_cnt_q, word_cnt_d;
    logic        frame_done_q, frame_done_d;
    logic        underrun_q, underrun_d;
    logic [7:0]  underrun_cnt_q, underrun_cnt_d;
    logic        two_ch_q, two_ch_d;
    logic [3:0]  num_word_q, num_word_d;

    logic        out_hs;
    logic        can_load;
    logic        sel_eff;
    logic        sel_valid;
    logic        load;
    logic [4:0]  frame_last;
    logic        last_word;
    logic        underrun_det;

    always_comb begin
        state_d = state_q;
        if (!cfg_en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = PRIME;
                PRIME:   if (master_ready_to_send_i) state_d = STREAM;
                STREAM:  if (!master_ready_to_send_i) state_d = PRIME;
                default: state_d = IDLE;
            endcase
        end
    end

    // Loading is also blocked on the edge that drops to IDLE so no accepted sample is flushed.
    assign out_hs       = fifo_valid_q & fifo_data_ready_i;
    assign can_load     = (state_q != IDLE) & cfg_en_i & (~fifo_valid_q | fifo_data_ready_i);
    assign sel_eff      = sel_q & two_ch_q;
    assign sel_valid    = sel_eff ? ch1_valid_i : ch0_valid_i;
    assign load         = can_load & sel_valid;
    assign frame_last   = two_ch_q ? {num_word_q, 1'b1} : {1'b0, num_word_q};
    assign last_word    = (word_cnt_q == frame_last);
    assign underrun_det = (state_q == STREAM) & fifo_data_ready_i & ~fifo_valid_q;

    assign ch0_ready_o  = can_load & ~sel_eff;
    assign ch1_ready_o  = can_load & sel_eff;

    always_comb begin
        tx_en_d        = (state_d != IDLE);
        fifo_data_d    = fifo_data_q;
        fifo_valid_d   = fifo_valid_q;
        sel_d          = sel_eff;
        word_cnt_d     = word_cnt_q;
        frame_done_d   = out_hs & last_word;
        underrun_d     = underrun_det;
        underrun_cnt_d = underrun_cnt_q;
        two_ch_d       = two_ch_q;
        num_word_d     = num_word_q;

        if ((state_q == IDLE) && (state_d == PRIME)) begin
            underrun_cnt_d = 8'd0;
        end else if (underrun_det && (underrun_cnt_q != 8'hFF)) begin
            underrun_cnt_d = underrun_cnt_q + 8'd1;
        end

        // Frame geometry is only re-sampled in IDLE or on a frame boundary.
        if ((state_q == IDLE) || (out_hs && last_word)) begin
            two_ch_d   = cfg_2ch_i;
            num_word_d = cfg_num_word_i;
        end

        if (state_d == IDLE) begin
            fifo_valid_d = 1'b0;
            sel_d        = 1'b0;
            word_cnt_d   = 5'd0;
        end else begin
            if (load) begin
                fifo_data_d  = sel_eff ? ch1_data_i : ch0_data_i;
                fifo_valid_d = 1'b1;
                sel_d        = two_ch_q & ~sel_eff;
            end else if (out_hs) begin
                fifo_valid_d = 1'b0;
            end
            if (out_hs) begin
                word_cnt_d = last_word ? 5'd0 : word_cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= IDLE;
            tx_en_q        <= 1'b0;
            fifo_data_q    <= 32'd0;
            fifo_valid_q   <= 1'b0;
            sel_q          <= 1'b0;
            word_cnt_q     <= 5'd0;
            frame_done_q   <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= 8'd0;
            two_ch_q       <= 1'b0;
            num_word_q     <= 4'd0;
        end else begin
            state_q        <= state_d;
            tx_en_q        <= tx_en_d;
            fifo_data_q    <= fifo_data_d;
            fifo_valid_q   <= fifo_valid_d;
            sel_q          <= sel_d;
            word_cnt_q     <= word_cnt_d;
            frame_done_q   <= frame_done_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
            two_ch_q       <= two_ch_d;
            num_word_q     <= num_word_d;
        end
    end

    assign fifo_data_o       = fifo_data_q;
    assign fifo_data_valid_o = fifo_valid_q;
    assign tx_en_o           = tx_en_q;
    assign frame_done_o      = frame_done_q;
    assign underrun_o        = underrun_q;
    assign underrun_cnt_o    = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_tx_dsp_sched.sv
// tb/tb_i2s_tx_dsp_sched.sv - bench for i2s_tx_dsp_sched: sequence-level reference model plus directed scenarios
module tb_i2s_tx_dsp_sched;

    logic        sck = 1'b0;
    logic        rstn_i = 1'b0;
    logic        cfg_en_i = 1'b0;
    logic        cfg_2ch_i = 1'b0;
    logic [3:0]  cfg_num_word_i = 4'd0;
    logic [31:0] ch0_data_i;
    logic        ch0_valid_i = 1'b0;
    logic        ch0_ready_o;
    logic [31:0] ch1_data_i;
    logic        ch1_valid_i = 1'b0;
    logic        ch1_ready_o;
    logic [31:0] fifo_data_o;
    logic        fifo_data_valid_o;
    logic        fifo_data_ready_i = 1'b0;
    logic        master_ready_to_send_i = 1'b0;
    logic        tx_en_o;
    logic        frame_done_o;
    logic        underrun_o;
    logic [7:0]  underrun_cnt_o;

    i2s_tx_dsp_sched dut (
        .sck_i                  (sck),
        .rstn_i                 (rstn_i),
        .cfg_en_i               (cfg_en_i),
        .cfg_2ch_i              (cfg_2ch_i),
        .cfg_num_word_i         (cfg_num_word_i),
        .ch0_data_i             (ch0_data_i),
        .ch0_valid_i            (ch0_valid_i),
        .ch0_ready_o            (ch0_ready_o),
        .ch1_data_i             (ch1_data_i),
        .ch1_valid_i            (ch1_valid_i),
        .ch1_ready_o            (ch1_ready_o),
        .fifo_data_o            (fifo_data_o),
        .fifo_data_valid_o      (fifo_data_valid_o),
        .fifo_data_ready_i      (fifo_data_ready_i),
        .master_ready_to_send_i (master_ready_to_send_i),
        .tx_en_o                (tx_en_o),
        .frame_done_o           (frame_done_o),
        .underrun_o             (underrun_o),
        .underrun_cnt_o         (underrun_cnt_o)
    );

    always #5 sck = ~sck;

    // Each source is an endless numbered sample stream; index advances only when popped.
    logic [31:0] i0 = 32'd0;
    logic [31:0] i1 = 32'd0;
    assign ch0_data_i = 32'hA000_0000 + i0;
    assign ch1_data_i = 32'hB000_0000 + i1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: words accepted vs words delivered since enable; output order is the interleave of the sources.
    int          m_state = 0;
    logic        m_tx = 1'b0;
    logic        m_fd = 1'b0;
    logic        m_ur = 1'b0;
    int          m_cnt = 0;
    int          m_acc = 0;
    int          m_out = 0;
    logic        m_2ch = 1'b0;
    int          m_flen = 1;
    logic [31:0] b0 = 32'd0;
    logic [31:0] b1 = 32'd0;
    logic        p0, p1, mv, sel, can, er0, er1, hs_out;
    int          ns;

    logic [31:0] log_q[$];
    logic [31:0] fd_words[$];
    int          ur_pulses = 0;
    int          ch1r_seen = 0;

    function automatic logic [31:0] seq(input int k);
        if (m_2ch)
            return (k % 2 == 0) ? 32'hA000_0000 + b0 + 32'(k / 2) : 32'hB000_0000 + b1 + 32'(k / 2);
        return 32'hA000_0000 + b0 + 32'(k);
    endfunction

    initial begin
        forever begin
            @(negedge sck);
            chk("tx_en", 32'(tx_en_o), 32'(m_tx));
            chk("fifo_valid", 32'(fifo_data_valid_o), 32'(m_acc > m_out));
            if (m_acc > m_out) chk("fifo_data", fifo_data_o, seq(m_out));
            chk("frame_done", 32'(frame_done_o), 32'(m_fd));
            chk("underrun", 32'(underrun_o), 32'(m_ur));
            chk("underrun_cnt", 32'(underrun_cnt_o), 32'(m_cnt));
            if (frame_done_o && log_q.size() > 0) fd_words.push_back(log_q[$]);
            if (underrun_o) ur_pulses++;
            #4;
            p0 = 1'b0;
            p1 = 1'b0;
            if (!rstn_i) begin
                m_state = 0; m_tx = 1'b0; m_fd = 1'b0; m_ur = 1'b0;
                m_cnt = 0; m_acc = 0; m_out = 0;
            end else begin
                mv  = (m_acc > m_out);
                sel = m_2ch && (m_acc % 2 == 1);
                can = (m_state != 0) && cfg_en_i && (!mv || fifo_data_ready_i);
                er0 = can && !sel;
                er1 = can && sel;
                chk("ch0_ready", 32'(ch0_ready_o), 32'(er0));
                chk("ch1_ready", 32'(ch1_ready_o), 32'(er1));
                if (ch1_ready_o) ch1r_seen++;
                p0 = er0 && ch0_valid_i;
                p1 = er1 && ch1_valid_i;
                hs_out = mv && fifo_data_ready_i;
                if (fifo_data_valid_o && fifo_data_ready_i) log_q.push_back(fifo_data_o);
                if (!cfg_en_i) ns = 0;
                else if (m_state == 0) ns = 1;
                else ns = master_ready_to_send_i ? 2 : 1;
                m_fd = hs_out && ((m_out + 1) % m_flen == 0);
                m_ur = (m_state == 2) && fifo_data_ready_i && !mv;
                if (m_state == 0 && ns == 1) begin
                    m_cnt  = 0;
                    m_2ch  = cfg_2ch_i;
                    m_flen = (int'(cfg_num_word_i) + 1) * (cfg_2ch_i ? 2 : 1);
                    b0 = i0;
                    b1 = i1;
                end else if (m_ur && m_cnt < 255) begin
                    m_cnt++;
                end
                if (ns == 0) begin
                    m_acc = 0;
                    m_out = 0;
                end else begin
                    m_acc += int'(p0 | p1);
                    m_out += int'(hs_out);
                end
                m_state = ns;
                m_tx = (ns != 0);
            end
            @(posedge sck);
            #1;
            if (p0) i0 = i0 + 32'd1;
            if (p1) i1 = i1 + 32'd1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sck);
    endtask

    logic [31:0] first_exp;
    int          bad;

    initial begin
        cyc(2);
        #1;
        chk("rst_tx_en", 32'(tx_en_o), 32'd0);
        chk("rst_valid", 32'(fifo_data_valid_o), 32'd0);
        chk("rst_data", fifo_data_o, 32'd0);
        chk("rst_cnt", 32'(underrun_cnt_o), 32'd0);
        @(negedge sck);
        rstn_i = 1'b1;
        cyc(2);

        // 2ch interleave, num_word=1
        cfg_2ch_i = 1'b1; cfg_num_word_i = 4'd1; ch0_valid_i = 1'b1; ch1_valid_i = 1'b1;
        fifo_data_ready_i = 1'b1; master_ready_to_send_i = 1'b1; cfg_en_i = 1'b1;
        log_q.delete(); fd_words.delete();
        cyc(10);
        #1;
        chk("t1_words", 32'(log_q.size()), 32'd8);
        if (log_q.size() >= 4) begin
            chk("t1_w0", log_q[0], 32'hA000_0000);
            chk("t1_w1", log_q[1], 32'hB000_0000);
            chk("t1_w2", log_q[2], 32'hA000_0001);
            chk("t1_w3", log_q[3], 32'hB000_0001);
        end
        chk("t1_fd_count", 32'(fd_words.size()), 32'd2);
        if (fd_words.size() > 0) chk("t1_fd_word", fd_words[0], 32'hB000_0001);
        @(negedge sck);
        cfg_en_i = 1'b0;
        cyc(2);

        // 1ch with ch1 permanently valid
        cfg_2ch_i = 1'b0; cfg_num_word_i = 4'd3; cfg_en_i = 1'b1;
        log_q.delete(); fd_words.delete(); ch1r_seen = 0;
        cyc(12);
        #1;
        chk("t2_ch1_ready_seen", 32'(ch1r_seen), 32'd0);
        chk("t2_words", 32'(log_q.size()), 32'd10);
        bad = 0;
        foreach (log_q[k]) if (log_q[k][31:28] != 4'hA) bad++;
        chk("t2_non_ch0_words", 32'(bad), 32'd0);
        chk("t2_fd_count", 32'(fd_words.size()), 32'd2);
        @(negedge sck);
        cfg_en_i = 1'b0;
        cyc(2);

        // underruns: none in PRIME, three from a 3-cycle ch0 stall
        cfg_num_word_i = 4'd7; ch0_valid_i = 1'b0; ch1_valid_i = 1'b0;
        master_ready_to_send_i = 1'b0; cfg_en_i = 1'b1; ur_pulses = 0;
        cyc(4);
        #1;
        chk("t3_prime_cnt", 32'(underrun_cnt_o), 32'd0);
        chk("t3_prime_tx_en", 32'(tx_en_o), 32'd1);
        @(negedge sck);
        master_ready_to_send_i = 1'b1; ch0_valid_i = 1'b1;
        cyc(5);
        ch0_valid_i = 1'b0;
        cyc(3);
        ch0_valid_i = 1'b1;
        cyc(4);
        #1;
        chk("t3_cnt", 32'(underrun_cnt_o), 32'd3);
        chk("t3_pulses", 32'(ur_pulses), 32'd3);

        // saturation
        @(negedge sck);
        ch0_valid_i = 1'b0;
        cyc(300);
        #1;
        chk("t4_cnt_sat", 32'(underrun_cnt_o), 32'd255);

        // enable dropped with a buffered word
        @(negedge sck);
        ch0_valid_i = 1'b1; fifo_data_ready_i = 1'b0;
        cyc(2);
        #1;
        chk("t5_buffered", 32'(fifo_data_valid_o), 32'd1);
        @(negedge sck);
        cfg_en_i = 1'b0;
        @(posedge sck);
        #1;
        chk("t5_idle_tx_en", 32'(tx_en_o), 32'd0);
        chk("t5_idle_valid", 32'(fifo_data_valid_o), 32'd0);
        @(negedge sck);
        cfg_2ch_i = 1'b1; cfg_num_word_i = 4'd1; cfg_en_i = 1'b1; fifo_data_ready_i = 1'b1;
        ch0_valid_i = 1'b1; ch1_valid_i = 1'b1; master_ready_to_send_i = 1'b1;
        first_exp = 32'hA000_0000 + i0;
        log_q.delete();
        cyc(6);
        #1;
        chk("t5_first_words", 32'(log_q.size() > 0), 32'd1);
        if (log_q.size() > 0) chk("t5_first_word", log_q[0], first_exp);
        chk("t5_cnt_cleared", 32'(underrun_cnt_o), 32'd0);

        // asynchronous reset mid-frame, then ready toggling
        @(negedge sck);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("t6_rst_tx_en", 32'(tx_en_o), 32'd0);
        chk("t6_rst_valid", 32'(fifo_data_valid_o), 32'd0);
        chk("t6_rst_data", fifo_data_o, 32'd0);
        chk("t6_rst_flags", {30'd0, frame_done_o, underrun_o}, 32'd0);
        chk("t6_rst_cnt", 32'(underrun_cnt_o), 32'd0);
        chk("t6_rst_ready", {30'd0, ch0_ready_o, ch1_ready_o}, 32'd0);
        @(negedge sck);
        rstn_i = 1'b1;
        log_q.delete();
        for (int k = 0; k < 40; k++) begin
            @(negedge sck);
            fifo_data_ready_i = (k % 3 != 2);
        end
        #1;
        chk("t6_words_flowing", 32'(log_q.size() >= 20), 32'd1);
        @(negedge sck);
        cfg_en_i = 1'b0;
        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
